// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: M-extension ALU selects and
// the multiplier sequencer state type.
package riscv_pkg;

    localparam logic [3:0] ALU_MUL    = 4'b1000;
    localparam logic [3:0] ALU_MULH   = 4'b1001;
    localparam logic [3:0] ALU_MULHSU = 4'b1010;
    localparam logic [3:0] ALU_MULHU  = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for the M-extension ops.
// Operands are reduced to magnitudes up front, multiplied unsigned over
// N cycles, then the sign is reapplied to the full 2N-bit product.
module mul_seq
    import riscv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUSel,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N);

    mul_state_t      state;
    logic [3:0]      op;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    mcand;
    logic            neg;
    logic [2*N:0]    prod;
    logic [CW-1:0]   cnt;

    logic            fire;
    logic            a_signed;
    logic            b_signed;
    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [N:0]      sum;
    logic [2*N:0]    prod_next;
    logic [2*N-1:0]  prod_fix;

    assign fire     = in_valid & in_ready & (ALUSel[3:2] == 2'b10);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Operand signedness, magnitudes, shift-add step and sign fix-up
    always_comb begin
        a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
        b_signed = (op == ALU_MULH);
        // Magnitude is held unsigned so the most negative value stays 2^(N-1)
        a_mag    = (a_signed && a_q[N-1]) ? (-a_q) : a_q;
        b_mag    = (b_signed && b_q[N-1]) ? (-b_q) : b_q;
        sum      = {1'b0, prod[2*N-1:N]} + {1'b0, mcand};
        if (prod[0]) begin
            prod_next = {sum, prod[N-1:0]} >> 1;
        end else begin
            prod_next = prod >> 1;
        end
        prod_fix = neg ? (-prod[2*N-1:0]) : prod[2*N-1:0];
    end

    // Sequencer FSM with registered result and valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            prod      <= '0;
            cnt       <= '0;
            res       <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        op    <= ALUSel;
                        a_q   <= A;
                        b_q   <= B;
                        state <= PREP;
                    end
                end
                PREP: begin
                    mcand <= a_mag;
                    prod  <= {{(N+1){1'b0}}, b_mag};
                    neg   <= (a_signed & a_q[N-1]) ^ (b_signed & b_q[N-1]);
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res       <= (op == ALU_MUL) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative multi-cycle multiplier sequencer for the RISC-V core's M-extension ops in the `4'b10xx` ALU-select space. These are the ops the single-cycle ALU leaves unimplemented. Sits beside the ALU in the execute stage: it accepts one multiply request via a valid/ready handshake, runs a radix-2 shift-add loop for N iterations, then presents a held result until the pipeline consumes it. The core stalls on `busy`.

## Interface
- `N`, 32, operand/result width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  sequencer can accept (high only in IDLE).
- `A`  in  N  rs1 operand.
- `B`  in  N  rs2 operand.
- `ALUSel`  in  4  `1000` MUL (low N bits), `1001` MULH (s×s high), `1010` MULHSU (A signed × B unsigned, high), `1011` MULHU (u×u high).
- `flush`  in  1  synchronous kill of any in-flight op.
- `out_valid`  out  1  `res` valid.
- `out_ready`  in  1  consumer takes result.
- `res`  out  N  result.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Accept (`fire`) = `in_valid & in_ready & (ALUSel[3:2]==2'b10)`. Other ALUSel values are never accepted and leave state unchanged.
- On fire, A, B and op are latched. Later input changes have no effect.
- States:
  - IDLE → PREP on fire.
  - PREP (1 cycle): form |A|, |B| per op signedness and record `neg` = sign(A) XOR sign(B), using only the signed operands. → CALC with the iteration counter = 0.
  - CALC (N cycles): on each cycle, if multiplier LSB is 1, add the multiplicand into the upper half of a 2N-bit product register; then shift right 1. The add carries into bit 2N. Counter increments; at N-1 → FIX.
  - FIX (1 cycle): if `neg`, take the 2N-bit two's complement of the product. Select the low N bits for `1000`, else the high N bits. → DONE.
  - DONE: `out_valid`=1 and `res` held stable. `out_ready` → IDLE.
- `in_ready` = (state==IDLE). No accept in the same cycle as DONE→IDLE.
- `flush` overrides everything: next state IDLE, `out_valid` drops next cycle, and the result is discarded. `flush` coinciding with fire: the op is not started.
- Operand edge cases: the most negative value (0x8000_0000) has magnitude 2^(N-1) and must not overflow the N-bit magnitude register, since it is held unsigned. Zero operand still takes the full latency; there is no early exit.

## Timing
- Reset values: state IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `res`=0, counter 0, product 0.
- Fixed latency: fire on edge T. `out_valid` rises after edge T+N+2, so 34 cycles for N=32, independent of operands.
- `res` and `out_valid` are registered outputs. There is no combinational path from `in_*` to `out_*`.
- `in_ready` and `busy` are decoded from state only.
- Backpressure: DONE holds indefinitely while `out_ready`=0.
- Asynchronous `rst` mid-operation returns all registers to reset values immediately. The first fire is possible on the first edge after deassertion.

## Structure
- Shared package `riscv_pkg`: ALUSel localparams (`ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`) reused by the ALU decoder, and the `mul_state_t` enum (IDLE, PREP, CALC, FIX, DONE).
- Single module. The counter width is `$clog2(N)`. There is no natural sub-module; the adder is inline.

## Test plan
- MUL 7×6: `res`=0x0000_002A, `out_valid` exactly 34 cycles after fire; `busy` high throughout.
- Signedness sweep:
  - MUL 0xFFFF_FFFF×0xFFFF_FFFF → 0x0000_0001.
  - MULH same operands → 0x0000_0000.
  - MULHU same operands → 0xFFFF_FFFE.
  - MULHSU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFF.
  - MULH 0x8000_0000×0x8000_0000 → 0x4000_0000.
- Backpressure: hold `out_ready`=0 for 10 cycles. `res` and `out_valid` stay stable, `in_ready`=0, and a new `in_valid` is ignored. Pulse `out_ready`; IDLE follows on the next cycle.
- Non-M ALUSel (`0000`) with `in_valid`=1: no accept, `busy` stays 0.
- `flush` at CALC iteration 10: IDLE next cycle and no `out_valid`. A new op MUL 3×5 then returns 0x0000_000F with full latency.
- Async `rst` asserted mid-CALC: outputs at reset values before the next clock edge. After release, MULHU 0x1_0000×0x1_0000 → 0x0000_0001.
